k_alu_seq: RTL and testbench

//  Next-generation execute unit for the datapath: a parametrised, registered ALU behind
//  a valid/ready handshake. Ops 0-15 are one-cycle; op 15 is a true Hamming distance.
//  Ops 16-19 (unsigned MUL low/high, DIV, REM) take WIDTH iterations.

---
 rtl/k_alu_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_k_alu_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k_alu_seq.sv
// k_alu_seq: registered execute unit behind a valid/ready handshake.
//
// Ops 0-15 and reserved ops 20-31 finish in one cycle. Ops 16-19 (unsigned
// MULL, MULH, DIV, REM) run WIDTH iterations of shift-add or restoring divide.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands/op presented
//   in_ready   unit can accept (transfer on in_valid & in_ready)
//   a, b       operands, captured at accept
//   op         operation select
//   out_valid  res/zero valid
//   out_ready  consumer accepts (transfer on out_valid & out_ready)
//   res        result
//   zero       res == 0
//   busy       iterative operation in progress
module k_alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             busy
);

    localparam int unsigned SW = $clog2(WIDTH);

    localparam logic [OP_W-1:0] OpAdd  = OP_W'(0);
    localparam logic [OP_W-1:0] OpSub  = OP_W'(1);
    localparam logic [OP_W-1:0] OpSlt  = OP_W'(2);
    localparam logic [OP_W-1:0] OpSgt  = OP_W'(3);
    localparam logic [OP_W-1:0] OpAnd  = OP_W'(4);
    localparam logic [OP_W-1:0] OpOr   = OP_W'(5);
    localparam logic [OP_W-1:0] OpXor  = OP_W'(6);
    localparam logic [OP_W-1:0] OpNot  = OP_W'(7);
    localparam logic [OP_W-1:0] OpNor  = OP_W'(8);
    localparam logic [OP_W-1:0] OpLui  = OP_W'(9);
    localparam logic [OP_W-1:0] OpSll  = OP_W'(10);
    localparam logic [OP_W-1:0] OpSrl  = OP_W'(11);
    localparam logic [OP_W-1:0] OpSra  = OP_W'(12);
    localparam logic [OP_W-1:0] OpInc  = OP_W'(13);
    localparam logic [OP_W-1:0] OpDec  = OP_W'(14);
    localparam logic [OP_W-1:0] OpHam  = OP_W'(15);
    localparam logic [OP_W-1:0] OpMull = OP_W'(16);
    localparam logic [OP_W-1:0] OpRem  = OP_W'(19);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e           r_state;
    state_e           w_state_nx;
    logic             r_rst_hold;
    logic [WIDTH-1:0] r_res;
    logic             r_zero;
    logic [WIDTH:0]   r_hi;     // MUL: upper partial product; DIV: partial remainder
    logic [WIDTH-1:0] r_lo;     // MUL: multiplier/low product; DIV: dividend/quotient
    logic [WIDTH-1:0] r_opnd;   // MUL: multiplicand; DIV: divisor
    logic [1:0]       r_mop;    // op[1:0] of the iterative op (bit1 = divide, bit0 = high half)
    logic [SW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_is_multi;
    logic [SW-1:0]    w_sh;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_pop;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH+1:0] w_diff;
    logic             w_ge;
    logic [WIDTH:0]   w_hi_nx;
    logic [WIDTH-1:0] w_lo_nx;
    logic [WIDTH-1:0] w_mres;

    // Blocks acceptance on the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_hold <= 1'b1;
        end else begin
            r_rst_hold <= 1'b0;
        end
    end

    assign in_ready   = ~r_rst_hold &
                        ((r_state == StIdle) | ((r_state == StDone) & out_ready));
    assign w_accept   = in_valid & in_ready;
    assign w_is_multi = (op >= OpMull) && (op <= OpRem);
    assign out_valid  = (r_state == StDone);
    assign busy       = (r_state == StExec);
    assign res        = r_res;
    assign zero       = r_zero;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_nx = w_is_multi ? StExec : StDone;
                end
            end
            StExec: begin
                if (r_cnt == '0) begin
                    w_state_nx = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_state_nx = w_is_multi ? StExec : StDone;
                    end else begin
                        w_state_nx = StIdle;
                    end
                end
            end
            default: w_state_nx = StIdle;
        endcase
    end

    // ---------------- one-cycle ALU ----------------
    assign w_sh = b[SW-1:0];
    assign w_x  = a ^ b;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_pop = w_pop + WIDTH'(w_x[i]);
        end
    end

    always_comb begin
        w_alu = '0;
        case (op)
            OpAdd:   w_alu = a + b;
            OpSub:   w_alu = a - b;
            OpSlt:   w_alu = WIDTH'($signed(a) < $signed(b));
            OpSgt:   w_alu = WIDTH'($signed(a) > $signed(b));
            OpAnd:   w_alu = a & b;
            OpOr:    w_alu = a | b;
            OpXor:   w_alu = w_x;
            OpNot:   w_alu = ~a;
            OpNor:   w_alu = ~(a | b);
            OpLui:   w_alu = b << (WIDTH / 2);
            OpSll:   w_alu = a << w_sh;
            OpSrl:   w_alu = a >> w_sh;
            OpSra:   w_alu = $unsigned($signed(a) >>> w_sh);
            OpInc:   w_alu = a + WIDTH'(4);
            OpDec:   w_alu = a - WIDTH'(4);
            OpHam:   w_alu = w_pop;
            default: w_alu = '0;
        endcase
    end

    // ---------------- iterative step ----------------
    always_comb begin
        w_sum    = r_hi + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_rem_sh = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
        w_diff   = {1'b0, w_rem_sh} - {2'b00, r_opnd};
        w_ge     = ~w_diff[WIDTH+1];
        if (r_mop[1]) begin
            // Restoring divide; divisor 0 always subtracts, giving all-ones / a.
            w_hi_nx = w_ge ? w_diff[WIDTH:0] : w_rem_sh;
            w_lo_nx = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_hi_nx = {1'b0, w_sum[WIDTH:1]};
            w_lo_nx = {w_sum[0], r_lo[WIDTH-1:1]};
        end
        w_mres = r_mop[0] ? w_hi_nx[WIDTH-1:0] : w_lo_nx;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res  <= '0;
            r_zero <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
            r_mop  <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            if (w_is_multi) begin
                r_mop  <= op[1:0];
                r_hi   <= '0;
                r_lo   <= op[1] ? a : b;
                r_opnd <= op[1] ? b : a;
                r_cnt  <= SW'(WIDTH - 1);
            end else begin
                r_res  <= w_alu;
                r_zero <= (w_alu == '0);
            end
        end else if (r_state == StExec) begin
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            r_cnt <= r_cnt - SW'(1);
            if (r_cnt == '0) begin
                r_res  <= w_mres;
                r_zero <= (w_mres == '0);
            end
        end
    end

endmodule

// File: tb/tb_k_alu_seq.sv
// Self-checking bench for k_alu_seq (WIDTH=32): directed vector table, random
// ops against an arithmetic reference model, and handshake/reset sequences.
module tb_k_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] res;
    logic        zero;
    logic        busy;

    k_alu_seq #(.WIDTH(32), .OP_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] ref_alu(input logic [4:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
        longint unsigned ux = x;
        longint unsigned uy = y;
        longint          sx = $signed(x);
        longint          sy = $signed(y);
        int              s  = int'(y % 32);
        int              cnt = 0;
        logic [31:0]     t = x ^ y;
        case (o)
            5'd0:  return 32'(ux + uy);
            5'd1:  return 32'(ux - uy);
            5'd2:  return (sx < sy) ? 32'd1 : 32'd0;
            5'd3:  return (sx > sy) ? 32'd1 : 32'd0;
            5'd4:  return x & y;
            5'd5:  return x | y;
            5'd6:  return x ^ y;
            5'd7:  return ~x;
            5'd8:  return ~(x | y);
            5'd9:  return 32'(uy * 65536);
            5'd10: return 32'(ux << s);
            5'd11: return 32'(ux >> s);
            5'd12: return 32'(sx >>> s);
            5'd13: return 32'(ux + 4);
            5'd14: return 32'(ux - 4);
            5'd15: begin
                for (int i = 0; i < 32; i++) cnt += int'(t[i]);
                return 32'(cnt);
            end
            5'd16: return 32'(ux * uy);
            5'd17: return 32'((ux * uy) >> 32);
            5'd18: return (y == 0) ? 32'hFFFF_FFFF : 32'(ux / uy);
            5'd19: return (y == 0) ? x : 32'(ux % uy);
            default: return 32'd0;
        endcase
    endfunction

    // Issue one op, wait for its result, record it and let it transfer.
    task automatic run_op(input logic [4:0] o, input logic [31:0] xa, input logic [31:0] xb,
                          output logic [31:0] r, output logic z, output int lat,
                          output int nbusy);
        int n = 0;
        op = o;
        a = xa;
        b = xb;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready before issue", in_ready, 1);
        tick();
        // Scramble inputs: operands must already be captured.
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 5'($urandom);
        lat = 1;
        nbusy = 0;
        while (!out_valid && lat < 100) begin
            nbusy += int'(busy);
            tick();
            lat++;
        end
        r = res;
        z = zero;
        tick();
    endtask

    logic [31:0] r, xa, xb, e;
    logic [4:0]  o;
    logic        z;
    int          lat, nb, stale;
    logic        multi;

    initial begin
        vecs[0]  = '{5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[1]  = '{5'd2,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[2]  = '{5'd12, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF};
        vecs[3]  = '{5'd11, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001};
        vecs[4]  = '{5'd15, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0020};
        vecs[5]  = '{5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[6]  = '{5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[7]  = '{5'd18, 32'd100,       32'd7,         32'd14};
        vecs[8]  = '{5'd19, 32'd100,       32'd7,         32'd2};
        vecs[9]  = '{5'd18, 32'd5,         32'd0,         32'hFFFF_FFFF};
        vecs[10] = '{5'd19, 32'd5,         32'd0,         32'd5};
        vecs[11] = '{5'd9,  32'h0000_0000, 32'h0000_1234, 32'h1234_0000};
        vecs[12] = '{5'd3,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[13] = '{5'd13, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0002};
        vecs[14] = '{5'd14, 32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFE};
        vecs[15] = '{5'd7,  32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
        vecs[16] = '{5'd8,  32'h0000_00F0, 32'h0000_000F, 32'hFFFF_FF00};
        vecs[17] = '{5'd25, 32'd5,         32'd5,         32'd0};
        vecs[18] = '{5'd10, 32'h0000_0001, 32'h0000_002F, 32'h0000_8000};
        vecs[19] = '{5'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};

        // ---- reset state ----
        #1 rst = 1'b1;
        tick();
        tick();
        check("reset out_valid", out_valid, 0);
        check("reset res", res, 0);
        check("reset zero", zero, 0);
        check("reset busy", busy, 0);
        check("reset in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("in_ready before first edge", in_ready, 0);
        tick();
        check("in_ready after first edge", in_ready, 1);

        // ---- directed vectors ----
        for (int i = 0; i < NV; i++) begin
            multi = (vecs[i].op >= 5'd16) && (vecs[i].op <= 5'd19);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat, nb);
            check($sformatf("vec%0d res", i), r, vecs[i].res);
            check($sformatf("vec%0d zero", i), z, (vecs[i].res == 0));
            check($sformatf("vec%0d latency", i), lat, multi ? 33 : 1);
            check($sformatf("vec%0d busy cycles", i), nb, multi ? 32 : 0);
        end

        // ---- random ops vs reference model ----
        for (int i = 0; i < 120; i++) begin
            o  = 5'($urandom_range(0, 31));
            xa = $urandom;
            case ($urandom_range(0, 3))
                0:       xb = 32'd0;
                1:       xb = 32'($urandom_range(1, 40));
                default: xb = $urandom;
            endcase
            e = ref_alu(o, xa, xb);
            multi = (o >= 5'd16) && (o <= 5'd19);
            run_op(o, xa, xb, r, z, lat, nb);
            check($sformatf("rand%0d op%0d res", i, o), r, e);
            check($sformatf("rand%0d op%0d zero", i, o), z, (e == 0));
            check($sformatf("rand%0d op%0d latency", i, o), lat, multi ? 33 : 1);
        end

        // ---- backpressure ----
        op = 5'd0;
        a = 32'd3;
        b = 32'd4;
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        check("bp accept ready", in_ready, 1);
        tick();
        a = 32'd10;
        b = 32'd20;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d out_valid", k), out_valid, 1);
            check($sformatf("bp%0d res", k), res, 32'd7);
            check($sformatf("bp%0d in_ready", k), in_ready, 0);
            tick();
        end
        check("bp held res", res, 32'd7);
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", in_ready, 1);
        tick();
        check("bp next out_valid", out_valid, 1);
        check("bp next res", res, 32'd30);
        in_valid = 1'b0;
        tick();
        check("bp drained", out_valid, 0);

        // ---- 10 back-to-back one-cycle ops in 11 cycles ----
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            o  = 5'($urandom_range(0, 15));
            xa = $urandom;
            xb = $urandom;
            e  = ref_alu(o, xa, xb);
            op = o;
            a = xa;
            b = xb;
            in_valid = 1'b1;
            #1;
            check($sformatf("b2b%0d in_ready", k), in_ready, 1);
            tick();
            check($sformatf("b2b%0d out_valid", k), out_valid, 1);
            check($sformatf("b2b%0d res", k), res, e);
        end
        in_valid = 1'b0;
        tick();
        check("b2b done after 11 cycles", out_valid, 0);

        // ---- reset in the middle of a DIV ----
        op = 5'd18;
        a = 32'd100;
        b = 32'd7;
        in_valid = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("div busy before reset", busy, 1);
        rst = 1'b1;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort res", res, 0);
        check("abort zero", zero, 0);
        check("abort busy", busy, 0);
        check("abort in_ready", in_ready, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("abort in_ready first edge", in_ready, 0);
        tick();
        check("abort in_ready after edge", in_ready, 1);
        run_op(5'd0, 32'd1, 32'd1, r, z, lat, nb);
        check("post-abort ADD res", r, 32'd2);
        check("post-abort ADD latency", lat, 1);
        stale = 0;
        repeat (40) begin
            tick();
            if (out_valid) stale++;
        end
        check("no stale DIV result", stale, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
